// File: rtl/tile_sequencer.sv
// Tile-level sequencer for the systolic MAC array: weight fetch, activation streaming,
// skew-compensated accumulator writes and readout. Optional macro: TILE_SEQ_WEIGHT_PREFETCH_EN.
module tile_sequencer #(
  parameter int unsigned MUL_SIZE   = 16,
  parameter int unsigned DIM_W      = 9,
  parameter int unsigned UB_ADDR_W  = 12,
  parameter int unsigned ACC_ADDR_W = 7,
  parameter int unsigned ARRAY_LAT  = 2 * MUL_SIZE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DIM_W-1:0]      h_dim_i,
  input  logic [DIM_W-1:0]      k_tiles_i,
  input  logic [DIM_W-1:0]      n_tiles_i,
  input  logic [UB_ADDR_W-1:0]  ub_base_addr_i,
  input  logic                  weight_tile_valid_i,
  input  logic                  stall_i,
  output logic                  weight_tile_pop_o,
  output logic                  weight_load_o,
  output logic                  weight_swap_o,
  output logic                  ub_rd_en_o,
  output logic [UB_ADDR_W-1:0]  ub_rd_addr_o,
  output logic                  mac_en_o,
  output logic                  acc_wr_en_o,
  output logic [ACC_ADDR_W-1:0] acc_wr_addr_o,
  output logic                  acc_add_o,
  output logic                  acc_rd_en_o,
  output logic [ACC_ADDR_W-1:0] acc_rd_addr_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_W, S_LOAD_W, S_STREAM, S_DRAIN, S_READOUT, S_DONE
  } state_t;

  localparam int unsigned    LCNT_W = (MUL_SIZE > 1) ? $clog2(MUL_SIZE) : 1;
  localparam logic [DIM_W-1:0] H_MAX = DIM_W'(2 ** ACC_ADDR_W);
  localparam logic [DIM_W-1:0] ONE   = DIM_W'(1);

  state_t                 state, state_nxt;
  logic [DIM_W-1:0]       h_cfg, k_cfg, n_cfg;
  logic [DIM_W-1:0]       k_idx, n_idx, row;
  logic [UB_ADDR_W-1:0]   base_cfg, k_off;
  logic [LCNT_W-1:0]      load_cnt;
  logic                   dl_vld [ARRAY_LAT];
  logic                   dl_add [ARRAY_LAT];
  logic [ACC_ADDR_W-1:0]  dl_row [ARRAY_LAT];

  logic zero_dim, last_row, last_k, last_n, load_last;
  logic rd_fire, rb_fire, drain_done, dl_rest_empty, swap_now, ld_active;
  logic pf_start, pf_run, pf_ready, pf_claimed;
  state_t tile_target;

  always_comb begin
    zero_dim   = (h_dim_i == '0) || (k_tiles_i == '0) || (n_tiles_i == '0);
    last_row   = (row == h_cfg - ONE);
    last_k     = (k_idx == k_cfg - ONE);
    last_n     = (n_idx == n_cfg - ONE);
    load_last  = (load_cnt == LCNT_W'(MUL_SIZE - 1));
    rd_fire    = (state == S_STREAM) && !stall_i;
    rb_fire    = (state == S_READOUT) && !stall_i;
    swap_now   = rd_fire && (row == '0);
    ld_active  = (state == S_LOAD_W) || pf_run;
    dl_rest_empty = 1'b1;
    for (int unsigned i = 0; i + 1 < ARRAY_LAT; i++) begin
      if (dl_vld[i]) dl_rest_empty = 1'b0;
    end
    // The pass is over once the only entry left is the one leaving the line this cycle.
    drain_done  = (state == S_DRAIN) && !stall_i && dl_rest_empty;
    tile_target = pf_ready ? S_STREAM : (pf_claimed ? S_LOAD_W : S_WAIT_W);
  end

`ifdef TILE_SEQ_WEIGHT_PREFETCH_EN
  logic pf_pend, pf_loaded;

  // A prefetch that is still loading at end of pass resumes in LOAD_W on the shared counter.
  assign pf_start   = ((state == S_STREAM) || (state == S_DRAIN) || (state == S_READOUT)) &&
                      !pf_pend && weight_tile_valid_i && !(last_k && last_n) && !swap_now;
  assign pf_run     = pf_start || (pf_pend && !pf_loaded);
  assign pf_ready   = pf_loaded || (pf_run && load_last);
  assign pf_claimed = pf_pend || pf_start;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pf_pend   <= 1'b0;
      pf_loaded <= 1'b0;
    end else if ((state != S_STREAM) && (state_nxt == S_STREAM)) begin
      pf_pend   <= 1'b0;
      pf_loaded <= 1'b0;
    end else begin
      if (pf_start) pf_pend <= 1'b1;
      if (pf_run && load_last) pf_loaded <= 1'b1;
    end
  end
`else
  assign pf_start   = 1'b0;
  assign pf_run     = 1'b0;
  assign pf_ready   = 1'b0;
  assign pf_claimed = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start_i) state_nxt = zero_dim ? S_DONE : S_WAIT_W;
      S_WAIT_W:  if (weight_tile_valid_i) state_nxt = S_LOAD_W;
      S_LOAD_W:  if (load_last) state_nxt = S_STREAM;
      S_STREAM:  if (rd_fire && last_row) state_nxt = S_DRAIN;
      S_DRAIN:   if (drain_done) state_nxt = last_k ? S_READOUT : tile_target;
      S_READOUT: if (rb_fire && last_row) state_nxt = last_n ? S_DONE : tile_target;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    weight_tile_pop_o = ((state == S_WAIT_W) && weight_tile_valid_i) || pf_start;
    weight_load_o     = ld_active;
    weight_swap_o     = swap_now;
    ub_rd_en_o        = rd_fire;
    mac_en_o          = rd_fire;
    ub_rd_addr_o      = rd_fire ? (base_cfg + k_off + UB_ADDR_W'(row)) : '0;
    acc_wr_en_o       = dl_vld[ARRAY_LAT-1] && !stall_i;
    acc_wr_addr_o     = acc_wr_en_o ? dl_row[ARRAY_LAT-1] : '0;
    acc_add_o         = acc_wr_en_o && dl_add[ARRAY_LAT-1];
    acc_rd_en_o       = rb_fire;
    acc_rd_addr_o     = rb_fire ? ACC_ADDR_W'(row) : '0;
    busy_o            = (state != S_IDLE);
    done_o            = (state == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cfg    <= '0;
      k_cfg    <= '0;
      n_cfg    <= '0;
      base_cfg <= '0;
      k_idx    <= '0;
      n_idx    <= '0;
      row      <= '0;
      k_off    <= '0;
      load_cnt <= '0;
      for (int unsigned i = 0; i < ARRAY_LAT; i++) begin
        dl_vld[i] <= 1'b0;
        dl_add[i] <= 1'b0;
        dl_row[i] <= '0;
      end
    end else begin
      if ((state == S_IDLE) && start_i) begin
        h_cfg    <= (h_dim_i > H_MAX) ? H_MAX : h_dim_i;
        k_cfg    <= k_tiles_i;
        n_cfg    <= n_tiles_i;
        base_cfg <= ub_base_addr_i;
        k_idx    <= '0;
        n_idx    <= '0;
        row      <= '0;
        k_off    <= '0;
      end
      if (ld_active) load_cnt <= load_last ? '0 : load_cnt + LCNT_W'(1);
      if (rd_fire || rb_fire) row <= last_row ? '0 : row + ONE;
      if (drain_done && !last_k) begin
        k_idx <= k_idx + ONE;
        k_off <= k_off + UB_ADDR_W'(h_cfg);
      end
      if (rb_fire && last_row) begin
        k_idx <= '0;
        k_off <= '0;
        n_idx <= n_idx + ONE;
      end
      if (!stall_i) begin
        dl_vld[0] <= rd_fire;
        dl_add[0] <= (k_idx != '0);
        dl_row[0] <= ACC_ADDR_W'(row);
        for (int unsigned i = 1; i < ARRAY_LAT; i++) begin
          dl_vld[i] <= dl_vld[i-1];
          dl_add[i] <= dl_add[i-1];
          dl_row[i] <= dl_row[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_tile_sequencer.sv
// Directed self-checking bench for tile_sequencer (MUL_SIZE=4, ARRAY_LAT=8); cycle 0 is the start cycle.
module tb_tile_sequencer;

  localparam int unsigned MUL_SIZE   = 4;
  localparam int unsigned DIM_W      = 9;
  localparam int unsigned UB_ADDR_W  = 12;
  localparam int unsigned ACC_ADDR_W = 7;
  localparam int unsigned ARRAY_LAT  = 8;

  logic                  clk = 1'b0;
  logic                  rst_i, start_i, weight_tile_valid_i, stall_i;
  logic [DIM_W-1:0]      h_dim_i, k_tiles_i, n_tiles_i;
  logic [UB_ADDR_W-1:0]  ub_base_addr_i;
  logic                  weight_tile_pop_o, weight_load_o, weight_swap_o, ub_rd_en_o, mac_en_o;
  logic [UB_ADDR_W-1:0]  ub_rd_addr_o;
  logic                  acc_wr_en_o, acc_add_o, acc_rd_en_o, busy_o, done_o;
  logic [ACC_ADDR_W-1:0] acc_wr_addr_o, acc_rd_addr_o;

  always #5 clk = ~clk;

  tile_sequencer #(
    .MUL_SIZE(MUL_SIZE), .DIM_W(DIM_W), .UB_ADDR_W(UB_ADDR_W),
    .ACC_ADDR_W(ACC_ADDR_W), .ARRAY_LAT(ARRAY_LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .h_dim_i(h_dim_i), .k_tiles_i(k_tiles_i),
    .n_tiles_i(n_tiles_i), .ub_base_addr_i(ub_base_addr_i),
    .weight_tile_valid_i(weight_tile_valid_i), .stall_i(stall_i),
    .weight_tile_pop_o(weight_tile_pop_o), .weight_load_o(weight_load_o),
    .weight_swap_o(weight_swap_o), .ub_rd_en_o(ub_rd_en_o), .ub_rd_addr_o(ub_rd_addr_o),
    .mac_en_o(mac_en_o), .acc_wr_en_o(acc_wr_en_o), .acc_wr_addr_o(acc_wr_addr_o),
    .acc_add_o(acc_add_o), .acc_rd_en_o(acc_rd_en_o), .acc_rd_addr_o(acc_rd_addr_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  int checks = 0;
  int failures = 0;

  logic [511:0] stall_pat, valid_pat, start_pat, rst_pat, busy_hist, act_hist;
  int alt_at;
  int pop_q[$], ld_q[$], sw_q[$], done_q[$];
  int rd_cyc[$], rd_adr[$], wr_cyc[$], wr_adr[$], wr_add[$], ar_cyc[$], ar_adr[$];
  int mac_bad;

  task automatic setup(input int h, input int k, input int n, input int base);
    h_dim_i        = DIM_W'(h);
    k_tiles_i      = DIM_W'(k);
    n_tiles_i      = DIM_W'(n);
    ub_base_addr_i = UB_ADDR_W'(base);
    stall_pat = '0; start_pat = '0; rst_pat = '0; valid_pat = '1;
    start_pat[0] = 1'b1;
    alt_at = 100000;
  endtask

  // Drives the per-cycle patterns and logs every output event with its cycle number.
  task automatic run(input int ncyc);
    pop_q.delete(); ld_q.delete(); sw_q.delete(); done_q.delete();
    rd_cyc.delete(); rd_adr.delete(); wr_cyc.delete(); wr_adr.delete(); wr_add.delete();
    ar_cyc.delete(); ar_adr.delete();
    mac_bad = 0; busy_hist = '0; act_hist = '0;
    for (int t = 0; t < ncyc; t++) begin
      rst_i = rst_pat[t]; start_i = start_pat[t]; stall_i = stall_pat[t];
      weight_tile_valid_i = valid_pat[t];
      if (t >= alt_at) begin
        h_dim_i = 9'd5;
        ub_base_addr_i = 12'h200;
      end
      @(negedge clk);
      if (weight_tile_pop_o) pop_q.push_back(t);
      if (weight_load_o) ld_q.push_back(t);
      if (weight_swap_o) sw_q.push_back(t);
      if (done_o) done_q.push_back(t);
      if (ub_rd_en_o) begin rd_cyc.push_back(t); rd_adr.push_back(int'(ub_rd_addr_o)); end
      if (acc_wr_en_o) begin
        wr_cyc.push_back(t); wr_adr.push_back(int'(acc_wr_addr_o)); wr_add.push_back(int'(acc_add_o));
      end
      if (acc_rd_en_o) begin ar_cyc.push_back(t); ar_adr.push_back(int'(acc_rd_addr_o)); end
      if (mac_en_o !== ub_rd_en_o) mac_bad++;
      busy_hist[t] = busy_o;
      act_hist[t] = |{weight_tile_pop_o, weight_load_o, weight_swap_o, ub_rd_en_o, ub_rd_addr_o,
                      mac_en_o, acc_wr_en_o, acc_wr_addr_o, acc_add_o, acc_rd_en_o, acc_rd_addr_o,
                      busy_o, done_o};
      @(posedge clk); #1;
    end
    rst_i = 1'b0; start_i = 1'b0; stall_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0; weight_tile_valid_i = 1'b0;
    h_dim_i = '0; k_tiles_i = '0; n_tiles_i = '0; ub_base_addr_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({weight_tile_pop_o, weight_load_o, weight_swap_o, ub_rd_en_o, ub_rd_addr_o, mac_en_o,
         acc_wr_en_o, acc_wr_addr_o, acc_add_o, acc_rd_en_o, acc_rd_addr_o, busy_o, done_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%0b done=%0b rd_en=%0b wr_en=%0b, required all 0",
               busy_o, done_o, ub_rd_en_o, acc_wr_en_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_tile();
    int exp_rd_c[3] = '{6, 7, 8};
    int exp_wr_c[3] = '{14, 15, 16};
    int exp_ar_c[3] = '{17, 18, 19};
    setup(3, 1, 1, 'h010);
    run(24);
    checks++;
    if (pop_q.size() != 1 || pop_q[0] != 1) begin
      failures++; $display("FAIL single_pop: count=%0d first=%0d, required 1 at cycle 1", pop_q.size(), pop_q[0]);
    end
    checks++;
    if (ld_q.size() != 4 || ld_q[0] != 2 || ld_q[3] != 5) begin
      failures++; $display("FAIL single_load: count=%0d first=%0d, required 4 from cycle 2", ld_q.size(), ld_q[0]);
    end
    checks++;
    if (sw_q.size() != 1 || sw_q[0] != 6) begin
      failures++; $display("FAIL single_swap: count=%0d at=%0d, required 1 at cycle 6", sw_q.size(), sw_q[0]);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= rd_cyc.size() || rd_cyc[i] != exp_rd_c[i] || rd_adr[i] != 'h010 + i) begin
        failures++; $display("FAIL single_read%0d: reads=%0d, required addr 0x%0h at cycle %0d",
                             i, rd_cyc.size(), 'h010 + i, exp_rd_c[i]);
      end
      checks++;
      if (i >= wr_cyc.size() || wr_cyc[i] != exp_wr_c[i] || wr_adr[i] != i || wr_add[i] != 0) begin
        failures++; $display("FAIL single_write%0d: writes=%0d, required acc %0d add 0 at cycle %0d",
                             i, wr_cyc.size(), i, exp_wr_c[i]);
      end
      checks++;
      if (i >= ar_cyc.size() || ar_cyc[i] != exp_ar_c[i] || ar_adr[i] != i) begin
        failures++; $display("FAIL single_accrd%0d: reads=%0d, required acc %0d at cycle %0d",
                             i, ar_cyc.size(), i, exp_ar_c[i]);
      end
    end
    checks++;
    if (rd_cyc.size() != 3 || wr_cyc.size() != 3 || ar_cyc.size() != 3 || mac_bad != 0) begin
      failures++; $display("FAIL single_counts: rd=%0d wr=%0d ar=%0d mac_bad=%0d, required 3/3/3/0",
                           rd_cyc.size(), wr_cyc.size(), ar_cyc.size(), mac_bad);
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != 20 || busy_hist[21] !== 1'b0 || busy_hist[19] !== 1'b1) begin
      failures++; $display("FAIL single_done: count=%0d at=%0d busy21=%0b, required 1 at cycle 20 then idle",
                           done_q.size(), done_q[0], busy_hist[21]);
    end
  endtask

  task automatic test_reduction();
    int exp_rd_c[4] = '{6, 7, 21, 22};
    int exp_wr_c[4] = '{14, 15, 29, 30};
    setup(2, 2, 1, 'h100);
    run(36);
    checks++;
    if (pop_q.size() != 2 || pop_q[0] != 1 || pop_q[1] != 16 || ld_q.size() != 8) begin
      failures++; $display("FAIL red_pops: pops=%0d second=%0d loads=%0d, required 2 pops (1,16) and 8 loads",
                           pop_q.size(), pop_q[1], ld_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rd_cyc.size() || rd_cyc[i] != exp_rd_c[i] || rd_adr[i] != 'h100 + i) begin
        failures++; $display("FAIL red_read%0d: reads=%0d, required addr 0x%0h at cycle %0d",
                             i, rd_cyc.size(), 'h100 + i, exp_rd_c[i]);
      end
      checks++;
      if (i >= wr_cyc.size() || wr_cyc[i] != exp_wr_c[i] || wr_adr[i] != i % 2 || wr_add[i] != i / 2) begin
        failures++; $display("FAIL red_write%0d: writes=%0d, required acc %0d add %0d at cycle %0d",
                             i, wr_cyc.size(), i % 2, i / 2, exp_wr_c[i]);
      end
    end
    checks++;
    if (ar_cyc.size() != 2 || ar_cyc[0] != 31 || ar_adr[1] != 1 || done_q.size() != 1 || done_q[0] != 33) begin
      failures++; $display("FAIL red_readout: accrd=%0d first=%0d done_at=%0d, required 2 from 31, done 33",
                           ar_cyc.size(), ar_cyc[0], done_q[0]);
    end
  endtask

  task automatic test_stall();
    int exp_rd_c[4] = '{6, 7, 11, 12};
    int exp_wr_c[4] = '{17, 19, 20, 21};
    int exp_ar_c[4] = '{22, 24, 25, 26};
    int stall_hits;
    setup(4, 1, 1, 'h020);
    stall_pat[8] = 1'b1; stall_pat[9] = 1'b1; stall_pat[10] = 1'b1;
    stall_pat[18] = 1'b1; stall_pat[23] = 1'b1;
    run(32);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rd_cyc.size() || rd_cyc[i] != exp_rd_c[i] || rd_adr[i] != 'h020 + i) begin
        failures++; $display("FAIL stall_read%0d: reads=%0d, required addr 0x%0h at cycle %0d",
                             i, rd_cyc.size(), 'h020 + i, exp_rd_c[i]);
      end
      checks++;
      if (i >= wr_cyc.size() || wr_cyc[i] != exp_wr_c[i] || wr_adr[i] != i) begin
        failures++; $display("FAIL stall_write%0d: writes=%0d, required acc %0d at cycle %0d",
                             i, wr_cyc.size(), i, exp_wr_c[i]);
      end
      checks++;
      if (i >= ar_cyc.size() || ar_cyc[i] != exp_ar_c[i] || ar_adr[i] != i) begin
        failures++; $display("FAIL stall_accrd%0d: reads=%0d, required acc %0d at cycle %0d",
                             i, ar_cyc.size(), i, exp_ar_c[i]);
      end
    end
    stall_hits = 0;
    foreach (rd_cyc[i]) if (stall_pat[rd_cyc[i]]) stall_hits++;
    foreach (wr_cyc[i]) if (stall_pat[wr_cyc[i]]) stall_hits++;
    foreach (ar_cyc[i]) if (stall_pat[ar_cyc[i]]) stall_hits++;
    checks++;
    if (stall_hits != 0 || rd_cyc.size() != 4 || done_q.size() != 1 || done_q[0] != 27) begin
      failures++; $display("FAIL stall_gating: enables_in_stall=%0d reads=%0d done_at=%0d, required 0/4/27",
                           stall_hits, rd_cyc.size(), done_q[0]);
    end
  endtask

  task automatic test_starvation();
    setup(1, 1, 1, 'h030);
    for (int t = 0; t <= 10; t++) valid_pat[t] = 1'b0;
    run(30);
    checks++;
    if (busy_hist[10:1] !== 10'h3FF || pop_q.size() != 1 || pop_q[0] != 11) begin
      failures++; $display("FAIL starve_wait: busy=%0h pops=%0d first=%0d, required busy 3ff, 1 pop at 11",
                           busy_hist[10:1], pop_q.size(), pop_q[0]);
    end
    checks++;
    if (ld_q.size() != 4 || ld_q[0] != 12 || rd_cyc.size() != 1 || rd_cyc[0] != 16 || rd_adr[0] != 'h030) begin
      failures++; $display("FAIL starve_resume: load_from=%0d read_at=%0d addr=0x%0h, required 12, 16, 0x30",
                           ld_q[0], rd_cyc[0], rd_adr[0]);
    end
    checks++;
    if (wr_cyc.size() != 1 || wr_cyc[0] != 24 || done_q.size() != 1 || done_q[0] != 26) begin
      failures++; $display("FAIL starve_finish: write_at=%0d done_at=%0d, required 24 and 26", wr_cyc[0], done_q[0]);
    end
  endtask

  task automatic test_degenerate();
    setup(3, 0, 1, 'h010);
    run(6);
    checks++;
    if (done_q.size() != 1 || done_q[0] != 1 || busy_hist[2] !== 1'b0) begin
      failures++; $display("FAIL degen_done: count=%0d at=%0d busy2=%0b, required 1 at cycle 1 then idle",
                           done_q.size(), done_q[0], busy_hist[2]);
    end
    checks++;
    if (pop_q.size() + ld_q.size() + rd_cyc.size() + wr_cyc.size() + ar_cyc.size() + sw_q.size() != 0) begin
      failures++; $display("FAIL degen_quiet: pops=%0d loads=%0d reads=%0d, required no activity",
                           pop_q.size(), ld_q.size(), rd_cyc.size());
    end
  endtask

  task automatic test_start_while_busy();
    setup(3, 1, 1, 'h010);
    start_pat[7] = 1'b1;
    alt_at = 7;
    run(34);
    checks++;
    if (rd_cyc.size() != 3 || rd_adr[2] != 'h012 || pop_q.size() != 1 || done_q.size() != 1 || done_q[0] != 20) begin
      failures++; $display("FAIL busy_start: reads=%0d last=0x%0h pops=%0d dones=%0d, required 3/0x12/1/1 at 20",
                           rd_cyc.size(), rd_adr[2], pop_q.size(), done_q.size());
    end
  endtask

  task automatic test_saturation();
    setup(300, 1, 1, 'hFF0);
    run(276);
    checks++;
    if (rd_cyc.size() != 128 || rd_adr[16] != 0 || rd_adr[127] != 'h06F || rd_cyc[127] != 133) begin
      failures++; $display("FAIL sat_reads: count=%0d addr16=0x%0h last=0x%0h at %0d, required 128, 0x0, 0x6f at 133",
                           rd_cyc.size(), rd_adr[16], rd_adr[127], rd_cyc[127]);
    end
    checks++;
    if (wr_cyc.size() != 128 || wr_cyc[127] != 141 || wr_adr[127] != 127) begin
      failures++; $display("FAIL sat_writes: count=%0d last at %0d acc %0d, required 128, 141, 127",
                           wr_cyc.size(), wr_cyc[127], wr_adr[127]);
    end
    checks++;
    if (ar_cyc.size() != 128 || ar_cyc[127] != 269 || ar_adr[127] != 127 || done_q.size() != 1 || done_q[0] != 270) begin
      failures++; $display("FAIL sat_readout: count=%0d last at %0d done at %0d, required 128, 269, 270",
                           ar_cyc.size(), ar_cyc[127], done_q[0]);
    end
  endtask

  task automatic test_reset_mid_stream();
    setup(3, 1, 1, 'h010);
    rst_pat[7] = 1'b1;
    run(24);
    checks++;
    if (rd_cyc.size() != 2 || act_hist[23:8] !== '0 || busy_hist[8] !== 1'b0) begin
      failures++; $display("FAIL midreset_abort: reads=%0d activity=%0h, required 2 reads then all 0 from cycle 8",
                           rd_cyc.size(), act_hist[23:8]);
    end
    setup(3, 1, 1, 'h010);
    run(24);
    checks++;
    if (rd_cyc.size() != 3 || rd_cyc[0] != 6 || rd_adr[0] != 'h010 || wr_cyc.size() != 3 || wr_cyc[2] != 16 ||
        done_q.size() != 1 || done_q[0] != 20) begin
      failures++; $display("FAIL midreset_restart: reads=%0d first_at=%0d writes=%0d done_at=%0d, required 3/6/3/20",
                           rd_cyc.size(), rd_cyc[0], wr_cyc.size(), done_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_reduction();
    test_stall();
    test_starvation();
    test_degenerate();
    test_start_while_busy();
    test_saturation();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tile_sequencer.md
Name: tile_sequencer

Overview:
- Parametrised tile-level sequencer for the systolic MAC array.
- Walks an N×K grid of weight tiles over H activation rows: fetches each weight tile, streams activations from the unified buffer, and steers accumulator writes with array-skew compensation.
- Accumulates partial sums across K tiles, then reads out each finished N-tile.
- Sits between the host/instruction decoder, the weight FIFO, the unified buffer and the accumulator bank.

Parameters:
- MUL_SIZE, 16, systolic array edge; weight load takes MUL_SIZE cycles.
- DIM_W, 9, width of dimension inputs.
- UB_ADDR_W, 12, unified buffer address width.
- ACC_ADDR_W, 7, accumulator address width; max rows = 2**ACC_ADDR_W.
- ARRAY_LAT, 2*MUL_SIZE, cycles from ub_rd_en_o to the matching accumulator write (ARRAY_LAT ≥ 1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  start pulse; honoured only in IDLE
- h_dim_i  in  DIM_W  activation rows per pass
- k_tiles_i  in  DIM_W  reduction tiles per output tile
- n_tiles_i  in  DIM_W  output column tiles
- ub_base_addr_i  in  UB_ADDR_W  activation base address
- weight_tile_valid_i  in  1  weight FIFO holds a complete tile
- stall_i  in  1  array/accumulator backpressure
- weight_tile_pop_o  out  1  consume one tile from FIFO
- weight_load_o  out  1  shift weights into shadow registers
- weight_swap_o  out  1  shadow→active weight swap
- ub_rd_en_o  out  1  activation read
- ub_rd_addr_o  out  UB_ADDR_W
- mac_en_o  out  1  array compute enable
- acc_wr_en_o  out  1
- acc_wr_addr_o  out  ACC_ADDR_W
- acc_add_o  out  1  1 = add to stored value, 0 = overwrite
- acc_rd_en_o  out  1
- acc_rd_addr_o  out  ACC_ADDR_W
- busy_o  out  1
- done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters and delay line cleared. Reset mid-operation aborts everything the next cycle; no further pops, reads or writes occur.
- start_i in IDLE latches config. A start while busy is ignored.
  - h_dim above 2**ACC_ADDR_W saturates to 2**ACC_ADDR_W.
  - Any dimension equal to 0: done_o pulses on the next cycle, no other activity.
- FSM states: IDLE → WAIT_W → LOAD_W → STREAM → DRAIN → (READOUT) → next tile or DONE → IDLE.
- WAIT_W: hold while weight_tile_valid_i = 0. When valid, assert weight_tile_pop_o for 1 cycle and enter LOAD_W.
- LOAD_W: weight_load_o = 1 for exactly MUL_SIZE cycles, then enter STREAM.
- STREAM:
  - weight_swap_o pulses in the first cycle, together with the first read.
  - Each unstalled cycle asserts ub_rd_en_o = mac_en_o = 1 with ub_rd_addr_o = ub_base + k_idx*h_dim + row. Address arithmetic is modulo 2**UB_ADDR_W.
  - row runs 0..h_dim-1.
- Skew delay line, ARRAY_LAT deep, carries {valid, row, add}. add = (k_idx ≠ 0).
  - The delay-line output drives acc_wr_en_o, acc_wr_addr_o and acc_add_o exactly ARRAY_LAT unstalled cycles after the matching read.
- stall_i = 1 freezes row counters, the delay line and readout. During a stall, ub_rd_en_o, mac_en_o, acc_wr_en_o and acc_rd_en_o are 0. The FSM state is held.
- stall_i has no effect in WAIT_W and LOAD_W.
- DRAIN: flush the delay line until the last write is issued.
  - If k_idx < k_tiles-1: increment k_idx, go to WAIT_W.
  - Otherwise go to READOUT.
- READOUT: acc_rd_en_o = 1 with acc_rd_addr_o = 0..h_dim-1, one per unstalled cycle. Then k_idx = 0 and n_idx increments.
  - If n_idx < n_tiles-1: go to WAIT_W.
  - Otherwise go to DONE.
- DONE: done_o = 1 for one cycle, then IDLE. busy_o = 1 in every state except IDLE.
- Counters are DIM_W wide. The final tile is detected by equality, so no wrap-around occurs.

Optional Feature:
- Macro TILE_SEQ_WEIGHT_PREFETCH_EN.
- Defined:
  - During STREAM/DRAIN/READOUT, if a further tile remains and weight_tile_valid_i = 1, pop and load the next tile into shadow registers. Loading takes MUL_SIZE cycles and is not affected by stall.
  - If the prefetch has completed at end of pass, skip WAIT_W/LOAD_W and enter STREAM directly.
  - Prefetch never starts during WAIT_W or DONE, or after the final tile.
- Undefined: strictly sequential; weight_load_o is only ever 1 in LOAD_W.

Test Plan (MUL_SIZE=4, ARRAY_LAT=8):
- Single tile: h=3, k=1, n=1, base=0x010, valid=1.
  - One pop, then 4 weight_load cycles.
  - Reads 0x010..0x012.
  - Writes to acc 0,1,2 with add=0, each 8 cycles after its read.
  - Reads from acc 0..2, then one done pulse.
- Reduction: h=2, k=2, n=1, base=0x100.
  - Pass 2 reads 0x102..0x103 with acc_add_o=1 to acc 0,1.
  - Readout occurs only after pass 2; exactly 2 pops.
- Stall: h=4, stall_i high for 3 cycles after the 2nd read.
  - Read addresses continue without gap or duplication.
  - Each write still lands 8 unstalled cycles after its read.
  - Write enables are 0 during the stall.
- Weight starvation: weight_tile_valid_i low for 10 cycles in WAIT_W.
  - No pop, no reads, busy_o=1.
  - Resumes 1 cycle after valid rises.
- Degenerate input and start while busy:
  - k=0: done_o at start+1, no other activity.
  - A second start during STREAM is ignored.
- Reset mid-STREAM: all outputs 0 next cycle, FSM in IDLE; a new start then runs normally.
